// File: rtl/ram_rtl_pkg.sv
// Shared definitions for the dual-port RAM core: controller states and
// default geometry matching the verification environment's defines.
package ram_rtl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  // INIT: self-clear sweep in progress; READY: normal read/write service.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_e;

endpackage : ram_rtl_pkg

// File: rtl/ram_dp_array.sv
// Plain storage array: one synchronous write port and one registered read
// port. Read returns the pre-write contents on an address collision; the
// surrounding core supplies write-first behaviour.
module ram_dp_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and registered read share one clocked block so tools map it to block RAM.
  // NOTE: the array and its read register carry no reset; resetting memory
  // defeats RAM inference, and the core clears contents with its own sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : ram_dp_array

// File: rtl/ram_dp_core.sv
// Dual-port RAM core: self-clearing after reset, then one write and one
// registered read per cycle with write-first bypass on address collision.
module ram_dp_core
  import ram_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_enb,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_enb,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_done,
  output logic                  req_err
);

  localparam int              DEPTH     = 2 ** ADDR_WIDTH;
  localparam [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  ram_state_e            state;
  ram_state_e            next_state;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  // Remembers whether the last read was a collision and what was written then.
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;
  // Low until the first read after reset, so rd_data shows 0 rather than
  // the unreset array read register.
  logic                  rd_loaded;

  // State register: INIT after reset, READY once the sweep finishes.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next state: leave INIT on the edge that clears the last word; READY is terminal.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    if (state == INIT && clr_addr == LAST_ADDR) begin
      next_state = READY;
    end
  end

  // Array port control: clear path owns the write port during INIT, user ports during READY.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = wr_addr;
    arr_wdata = wr_data;
    arr_re    = 1'b0;
    case (state)
      INIT: begin
        arr_we    = 1'b1;
        arr_waddr = clr_addr;
        arr_wdata = '0;
      end
      READY: begin
        arr_we = wr_enb;
        arr_re = rd_enb;
      end
      default: ;
    endcase
  end

  // Clear counter: walks every address once while in INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
    end else if (state == INIT) begin
      clr_addr <= clr_addr + 1'b1;
    end
  end

  // Read handshake, bypass capture and request-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      req_err   <= 1'b0;
      rd_loaded <= 1'b0;
      byp_hit   <= 1'b0;
      byp_data  <= '0;
    end else begin
      rd_valid <= arr_re;
      req_err  <= (state == INIT) && (wr_enb || rd_enb);
      if (arr_re) begin
        rd_loaded <= 1'b1;
        byp_hit   <= wr_enb && (wr_addr == rd_addr);
        byp_data  <= wr_data;
      end
    end
  end

  ram_dp_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (arr_re),
    .raddr(rd_addr),
    .rdata(arr_rdata)
  );

  // Output selection is driven only by registers, keeping inputs off output paths.
  assign rd_data   = !rd_loaded ? '0 : (byp_hit ? byp_data : arr_rdata);
  assign init_done = (state == READY);

endmodule : ram_dp_core
